// File: rtl/mini_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module   : mini_resp_checker
//  Purpose  : Response-side checker for a 4-input combinational stimulus
//             sweep. Each applied vector is sampled together with the DUT
//             output z and compared against a 16-entry truth table. The
//             checker tracks vector coverage, counts checks and mismatches,
//             and latches the first failing vector. It reports done/pass once
//             all 16 vectors have been seen, or aborts on an idle timeout.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             in   1      rising-edge clock
//    rst             in   1      asynchronous, active-high reset
//    start           in   1      1-cycle pulse: clear all results, enter RUN
//    vec_valid       in   1      vec/z pair valid this cycle
//    vec             in   4      applied input vector
//    z               in   1      DUT output for vec
//    busy            out  1      checker is in RUN
//    done            out  1      checker is in DONE
//    aborted         out  1      checker is in ABORT
//    pass            out  1      done with zero mismatches
//    chk_count       out  CNT_W  number of compared samples (saturating)
//    err_count       out  CNT_W  number of mismatching samples (saturating)
//    cover_map       out  16     bit v set once vector v has been checked
//    first_fail_vld  out  1      a mismatch has been recorded
//    first_fail_vec  out  4      vector of the first mismatch
// ============================================================================
module mini_resp_checker #(
  parameter logic [15:0] TRUTH_TABLE = 16'h8CEF,
  parameter int          CNT_W       = 8,
  parameter int          TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [3:0]       vec,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             pass,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count,
  output logic [15:0]      cover_map,
  output logic             first_fail_vld,
  output logic [3:0]       first_fail_vec
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int               IDLE_W    = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Internal signals
  // --------------------------------------------------------------------------
  state_t            state;
  state_t            state_nxt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              accept;
  logic              idle_expire;

  // Stage-1 sample register
  logic              s1_vld;
  logic [3:0]        s1_vec;
  logic              s1_z;
  logic              s1_mismatch;

  // A sample is only taken while running; a start in the same cycle wins and
  // the sample is dropped.
  assign accept = vec_valid && (state == S_RUN) && !start;

  // The idle counter holds the number of idle RUN cycles already elapsed, so
  // the TIMEOUT-th consecutive idle cycle is the one that moves us to ABORT.
  assign idle_expire = (state == S_RUN) && !vec_valid && (idle_cnt == IDLE_LAST);

  assign s1_mismatch = (s1_z != TRUTH_TABLE[s1_vec]);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    aborted   = 1'b0;

    if (start) begin
      // start restarts from any state, including RUN itself
      state_nxt = S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          // cover_map is registered, so DONE follows one cycle after the
          // update that completes coverage.
          if (cover_map == 16'hFFFF) begin
            state_nxt = S_DONE;
          end else if (idle_expire) begin
            state_nxt = S_ABORT;
          end
        end
        default: begin
          state_nxt = state;
        end
      endcase
    end

    case (state)
      S_RUN:   busy    = 1'b1;
      S_DONE:  done    = 1'b1;
      S_ABORT: aborted = 1'b1;
      default: begin
        busy    = 1'b0;
        done    = 1'b0;
        aborted = 1'b0;
      end
    endcase
  end

  assign pass = done && (err_count == '0);

  // --------------------------------------------------------------------------
  // Idle counter: counts consecutive RUN cycles without vec_valid
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (start || accept || (state != S_RUN)) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: capture the vec/z pair
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_vec <= 4'd0;
      s1_z   <= 1'b0;
    end else begin
      // accept is already low during start, which discards any sample that
      // would otherwise be in flight across a restart.
      s1_vld <= accept;
      if (accept) begin
        s1_vec <= vec;
        s1_z   <= z;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: compare and update results
  // --------------------------------------------------------------------------
  // A sample captured on the last RUN cycle still completes here even though
  // the state has moved on to DONE or ABORT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_count      <= '0;
      err_count      <= '0;
      cover_map      <= 16'h0000;
      first_fail_vld <= 1'b0;
      first_fail_vec <= 4'd0;
    end else if (start) begin
      chk_count      <= '0;
      err_count      <= '0;
      cover_map      <= 16'h0000;
      first_fail_vld <= 1'b0;
      first_fail_vec <= 4'd0;
    end else if (s1_vld) begin
      if (chk_count != CNT_MAX) begin
        chk_count <= chk_count + CNT_W'(1);
      end
      if (s1_mismatch) begin
        if (err_count != CNT_MAX) begin
          err_count <= err_count + CNT_W'(1);
        end
        if (!first_fail_vld) begin
          first_fail_vld <= 1'b1;
          first_fail_vec <= s1_vec;
        end
      end
      // Re-checking an already covered vector leaves the map unchanged.
      cover_map[s1_vec] <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mini_resp_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mini_resp_checker
//  Purpose  : Self-checking bench for mini_resp_checker. A second instance
//             with 2-bit counters shares the stimulus to exercise saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mini_resp_checker;

  localparam logic [15:0] TT = 16'h8CEF;
  localparam int TOUT  = 64;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_DONE = 2, ST_ABORT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic vec_valid = 1'b0;
  logic [3:0] vec = 4'd0;
  logic z = 1'b0;

  logic busy, done, aborted, pass, first_fail_vld;
  logic [7:0] chk_count, err_count;
  logic [15:0] cover_map;
  logic [3:0] first_fail_vec;

  logic s_busy, s_done, s_aborted, s_pass, s_ffv;
  logic [1:0] s_chk, s_err;
  logic [15:0] s_cover;
  logic [3:0] s_ffvec;

  int total = 0;
  int bad = 0;

  // reference model state
  int         m_state;
  int         m_chk;
  int         m_err;
  logic [15:0] m_cover;
  bit         m_ffv;
  logic [3:0] m_ffvec;

  always #5 clk = ~clk;

  mini_resp_checker #(.TRUTH_TABLE(TT), .CNT_W(8), .TIMEOUT(TOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec(vec), .z(z),
    .busy(busy), .done(done), .aborted(aborted), .pass(pass),
    .chk_count(chk_count), .err_count(err_count), .cover_map(cover_map),
    .first_fail_vld(first_fail_vld), .first_fail_vec(first_fail_vec)
  );

  mini_resp_checker #(.TRUTH_TABLE(TT), .CNT_W(2), .TIMEOUT(TOUT)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .vec_valid(vec_valid), .vec(vec), .z(z),
    .busy(s_busy), .done(s_done), .aborted(s_aborted), .pass(s_pass),
    .chk_count(s_chk), .err_count(s_err), .cover_map(s_cover),
    .first_fail_vld(s_ffv), .first_fail_vec(s_ffvec)
  );

  function automatic int sat(int v, int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear(int st);
    m_state = st;
    m_chk   = 0;
    m_err   = 0;
    m_cover = 16'h0000;
    m_ffv   = 1'b0;
    m_ffvec = 4'd0;
  endtask

  // A sample only counts while the checker is running; completing coverage
  // ends the run.
  task automatic model_sample(logic [3:0] v, logic zz);
    if (m_state == ST_RUN) begin
      m_chk++;
      if (zz !== TT[v]) begin
        m_err++;
        if (!m_ffv) begin
          m_ffv   = 1'b1;
          m_ffvec = v;
        end
      end
      m_cover[v] = 1'b1;
      if (m_cover == 16'hFFFF) m_state = ST_DONE;
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".busy"},    32'(busy),    32'(m_state == ST_RUN));
    chk({tag, ".done"},    32'(done),    32'(m_state == ST_DONE));
    chk({tag, ".aborted"}, 32'(aborted), 32'(m_state == ST_ABORT));
    chk({tag, ".pass"},    32'(pass),    32'(m_state == ST_DONE && m_err == 0));
    chk({tag, ".chk"},     32'(chk_count), 32'(sat(m_chk, 255)));
    chk({tag, ".err"},     32'(err_count), 32'(sat(m_err, 255)));
    chk({tag, ".cover"},   32'(cover_map), 32'(m_cover));
    chk({tag, ".ffv"},     32'(first_fail_vld), 32'(m_ffv));
    chk({tag, ".ffvec"},   32'(first_fail_vec), 32'(m_ffvec));
    chk({tag, ".sat_chk"}, 32'(s_chk),   32'(sat(m_chk, 3)));
    chk({tag, ".sat_err"}, 32'(s_err),   32'(sat(m_err, 3)));
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear(ST_RUN);
  endtask

  task automatic send(logic [3:0] v, logic zz);
    vec_valid = 1'b1;
    vec       = v;
    z         = zz;
    tick();
    vec_valid = 1'b0;
    model_sample(v, zz);
  endtask

  task automatic settle();
    tick();
    tick();
  endtask

  initial begin
    logic [3:0] rv;
    logic       rz;
    int         n;

    model_clear(ST_IDLE);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_all("reset");

    // T1: full correct sweep, one vector per 10 cycles
    do_start();
    check_all("t1_start");
    send(4'd0, TT[0]);
    chk("t1_lat_hold", 32'(chk_count), 32'd0);
    tick();
    chk("t1_lat_upd", 32'(chk_count), 32'd1);
    repeat (8) tick();
    for (int v = 1; v < 16; v++) begin
      send(4'(v), TT[v]);
      repeat (9) tick();
    end
    check_all("t1_done");
    // vec_valid outside RUN is ignored
    send(4'd3, ~TT[3]);
    settle();
    check_all("t1_ignore");

    // T2: mismatches at vectors 5 and 9
    do_start();
    check_all("t2_restart");
    for (int v = 0; v < 16; v++) begin
      send(4'(v), TT[v] ^ ((v == 5) || (v == 9)));
      repeat (9) tick();
    end
    check_all("t2_done");

    // T3: vectors 0..14 only, then idle until abort
    do_start();
    for (int v = 0; v < 15; v++) begin
      send(4'(v), TT[v]);
      if (v < 14) repeat (9) tick();
    end
    repeat (TOUT - 1) tick();
    check_all("t3_before_abort");
    tick();
    m_state = ST_ABORT;
    check_all("t3_abort");

    // T4: vec 3 three times, then 0..15 back-to-back
    do_start();
    repeat (3) send(4'd3, TT[3]);
    for (int v = 0; v < 16; v++) send(4'(v), TT[v]);
    tick();
    chk("t4_done_lag", 32'(done), 32'd0);
    chk("t4_chk19", 32'(chk_count), 32'd19);
    tick();
    check_all("t4_done");

    // T5: five mismatches, saturating the 2-bit instance
    do_start();
    for (int v = 0; v < 5; v++) send(4'(v), ~TT[v]);
    settle();
    check_all("t5_sat");

    // T6: async reset mid-RUN with a sample in flight
    do_start();
    for (int i = 0; i < 7; i++) begin
      rv = 4'($urandom_range(0, 15));
      send(rv, TT[rv]);
    end
    send(4'd7, ~TT[7]);
    rst = 1'b1;
    #1;
    model_clear(ST_IDLE);
    check_all("t6_rst_async");
    tick();
    rst = 1'b0;
    tick();
    check_all("t6_after_rst");
    // start with vec_valid in the same cycle: sample dropped
    start     = 1'b1;
    vec_valid = 1'b1;
    vec       = 4'd2;
    z         = ~TT[2];
    tick();
    start     = 1'b0;
    vec_valid = 1'b0;
    model_clear(ST_RUN);
    settle();
    check_all("t6_start_drop");

    // T7: randomized vectors, errors and gaps until coverage completes
    do_start();
    n = 0;
    while (m_state == ST_RUN && n < 500) begin
      repeat ($urandom_range(0, 4)) tick();
      rv = 4'($urandom_range(0, 15));
      rz = ($urandom_range(0, 3) == 0) ? ~TT[rv] : TT[rv];
      send(rv, rz);
      n++;
    end
    settle();
    check_all("t7_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
